// File: rtl/winograd_pkg.sv
// Shared definitions for the F(2x2,3x3) Winograd datapath: tile geometry,
// pixel type and the single flattened-tile layout used by feeder and PE.
package winograd_pkg;

    localparam int TILE_EDGE          = 4;
    localparam int TILE_ELEMS         = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CHANNELS   = 3;
    localparam int PIX_W              = DEFAULT_DATA_WIDTH * DEFAULT_CHANNELS;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } fill_state_t;

    // Element (i,j) of channel k sits at this element index in a flattened tile.
    function automatic int tile_offset(input int i, input int j, input int k);
        return (TILE_EDGE * i + j) + TILE_ELEMS * k;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Three-bank row store for the tile buffer: one write port, three read ports.
// Reads are combinational, so a same-cycle write is seen only after the edge.
module line_buffer_ram
    import winograd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = PIX_W,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [1:0]       wr_bank,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata [3]
);

    for (genvar b = 0; b < 3; b++) begin : g_bank
        logic [WIDTH-1:0] mem [DEPTH];

        // NOTE: storage is deliberately not reset; every row is written before it is read.
        always_ff @(posedge clk) begin
            if (we && wr_bank == 2'(b)) begin
                mem[addr] <= wdata;
            end
        end

        assign rdata[b] = mem[addr];
    end

endmodule

// File: rtl/winograd_tile_buffer.sv
// Raster pixel stream in, overlapping stride-2 4x4xCHANNELS tiles out,
// flattened in the Winograd PE input layout.
module winograd_tile_buffer
    import winograd_pkg::*;
#(
    parameter int INPUT_TILE_SIZE  = TILE_EDGE,
    parameter int INPUT_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS         = DEFAULT_CHANNELS,
    parameter int IMG_WIDTH        = 32,
    parameter int IMG_HEIGHT       = 32,
    localparam int PW  = INPUT_DATA_WIDTH * CHANNELS,
    localparam int TRW = $clog2(IMG_HEIGHT / 2),
    localparam int TCW = $clog2(IMG_WIDTH / 2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PW-1:0]            in_pixel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [TILE_ELEMS*PW-1:0] out_tile,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRW-1:0]           tile_row,
    output logic [TCW-1:0]           tile_col,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    if (INPUT_TILE_SIZE != 4 || IMG_WIDTH < 4 || IMG_HEIGHT < 4 ||
        (IMG_WIDTH % 2) != 0 || (IMG_HEIGHT % 2) != 0) begin : g_param_check
        $error("winograd_tile_buffer: tile edge must be 4, image dims even and >= 4");
    end

    fill_state_t   state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    slot;
    logic          accept, emit, col_last, row_last;
    logic [RW-1:0] row_m3;
    logic [CW-1:0] col_m3;
    logic [PW-1:0] rd_bank [3];
    logic [PW-1:0] rd_m3, rd_m2, rd_m1;
    logic [PW-1:0] win      [4][4];
    logic [PW-1:0] win_next [4][4];
    logic [TILE_ELEMS*PW-1:0] tile_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign emit     = accept && (state == S_RUN) && row[0] && col[0] && (col >= CW'(3));
    assign row_m3   = row - RW'(3);
    assign col_m3   = col - CW'(3);

    line_buffer_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PW)
    ) u_line_buffer (
        .clk     (clk),
        .we      (accept),
        .wr_bank (slot),
        .addr    (col),
        .wdata   (in_pixel),
        .rdata   (rd_bank)
    );

    // slot holds row mod 3: it is also where row-3 lives until overwritten this beat.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_m3 = rd_bank[0];
        rd_m2 = rd_bank[1];
        rd_m1 = rd_bank[2];
        case (slot)
            2'd1: begin rd_m3 = rd_bank[1]; rd_m2 = rd_bank[2]; rd_m1 = rd_bank[0]; end
            2'd2: begin rd_m3 = rd_bank[2]; rd_m2 = rd_bank[0]; rd_m1 = rd_bank[1]; end
            default: ;
        endcase
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_next[r][c] = win[r][c+1];
            end
        end
        win_next[0][3] = rd_m3;
        win_next[1][3] = rd_m2;
        win_next[2][3] = rd_m1;
        win_next[3][3] = in_pixel;
    end

    always_comb begin
        tile_next = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    tile_next[tile_offset(i, j, k)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] =
                        win_next[i][j][k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FILL;
            col        <= '0;
            row        <= '0;
            slot       <= '0;
            out_valid  <= 1'b0;
            out_tile   <= '0;
            tile_row   <= '0;
            tile_col   <= '0;
            frame_done <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[r][c] <= win_next[r][c];
                    end
                end

                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row        <= '0;
                        slot       <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        row  <= row + RW'(1);
                        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
                    end
                end else begin
                    col <= col + CW'(1);
                end

                case (state)
                    S_FILL: if (col_last && row == RW'(2)) state <= S_RUN;
                    S_RUN:  if (col_last && row_last)      state <= S_FILL;
                    default: state <= S_FILL;
                endcase
            end

            // A freshly completed tile wins over retiring the held one.
            if (emit) begin
                out_valid <= 1'b1;
                out_tile  <= tile_next;
                tile_row  <= TRW'(row_m3 >> 1);
                tile_col  <= TCW'(col_m3 >> 1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_winograd_tile_buffer.sv
// Directed bench for winograd_tile_buffer on a 6x6, 3-channel image; pixel
// channel k at (r,c) is 6r+c+base+64k (mod 256).
module tb_winograd_tile_buffer;

    localparam int W  = 8;
    localparam int CH = 3;
    localparam int IW = 6;
    localparam int IH = 6;
    localparam int PW = W * CH;
    localparam int TW = 16 * PW;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic [TW-1:0] out_tile;
    logic          out_valid;
    logic [1:0]    tile_row;
    logic [1:0]    tile_col;
    logic          frame_done;

    winograd_tile_buffer #(
        .INPUT_TILE_SIZE  (4),
        .INPUT_DATA_WIDTH (W),
        .CHANNELS         (CH),
        .IMG_WIDTH        (IW),
        .IMG_HEIGHT       (IH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_tile   (out_tile),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tile;
        int            r;
        int            c;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   fd_count = 0;
    bit   fd_on_last = 1'b0;

    // Tiles are logged when a transfer will happen at the coming rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) q.push_back('{out_tile, int'(tile_row), int'(tile_col)});
            if (frame_done) begin
                fd_count++;
                fd_on_last = out_valid && tile_row == 2'd1 && tile_col == 2'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [TW-1:0] actual, input logic [TW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] pix_val(input int r, input int c, input int k, input int base);
        int v;
        v = IW * r + c + base + 64 * k;
        return 8'(v % 256);
    endfunction

    function automatic logic [PW-1:0] make_pix(input int r, input int c, input int base);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < CH; k++) p[k*W +: W] = pix_val(r, c, k, base);
        return p;
    endfunction

    function automatic logic [TW-1:0] model_tile(input int tr, input int tc, input int base);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < CH; k++)
                    t[((4*i + j) + 16*k)*W +: W] = pix_val(2*tr + i, 2*tc + j, k, base);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input logic [PW-1:0] pix, input int valid_pct);
        int guard;
        bit taken;
        while (valid_pct < 100 && int'($urandom_range(99)) >= valid_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_pixel = pix;
        guard = 0;
        taken = 1'b0;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready;
            tick();
            guard++;
            if (!taken && guard >= 200) begin
                check("accept_timeout", 0, 1);
                taken = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int valid_pct, input int n_pix);
        for (int p = 0; p < n_pix; p++) push_pixel(make_pix(p / IW, p % IW, base), valid_pct);
    endtask

    task automatic check_tiles(input string tag, input int base, input int first);
        for (int t = 0; t < 4; t++) begin
            if (first + t < q.size()) begin
                check($sformatf("%s_t%0d_row", tag, t), q[first+t].r, t / 2);
                check($sformatf("%s_t%0d_col", tag, t), q[first+t].c, t % 2);
                check($sformatf("%s_t%0d_data", tag, t), q[first+t].tile, model_tile(t / 2, t % 2, base));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_out_tile"}, out_tile, 0);
        check({tag, "_tile_row"}, tile_row, 0);
        check({tag, "_tile_col"}, tile_col, 0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // Basic frame plus channel layout spot checks.
        q.delete();
        fd_count = 0;
        send_frame(0, 100, NPIX);
        repeat (3) tick();
        check("basic_ntiles", q.size(), 4);
        check_tiles("basic", 0, 0);
        if (q.size() >= 4) begin
            check("basic_t00_e00", q[0].tile[7:0], 0);
            check("basic_t00_e33", q[0].tile[15*8 +: 8], 21);
            check("basic_t11_e00", q[3].tile[7:0], 14);
            check("chan_t00_i1j2k1", q[0].tile[((4*1 + 2) + 16*1)*8 +: 8], 72);
            check("chan_t00_i2j3k2", q[0].tile[((4*2 + 3) + 16*2)*8 +: 8], 143);
        end
        check("basic_frame_done_count", fd_count, 1);
        check("basic_frame_done_on_last", fd_on_last, 1);

        // Backpressure: stall after the first tile is taken.
        q.delete();
        fork
            send_frame(0, 100, NPIX);
            begin
                int guard;
                bit stable;
                logic [TW-1:0] held;
                guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                if (!out_valid) check("bp_first_tile_timeout", 0, 1);
                tick();
                out_ready = 1'b0;
                guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                if (!out_valid) check("bp_second_tile_timeout", 0, 1);
                check("bp_in_ready_low", in_ready, 0);
                held = out_tile;
                check("bp_held_tile", held, model_tile(0, 1, 0));
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (out_tile !== held || !out_valid || in_ready) stable = 1'b0;
                end
                check("bp_hold_stable", stable, 1);
                tick();
                out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        check("bp_ntiles", q.size(), 4);
        check_tiles("bp", 0, 0);

        // Back-to-back frames, second offset by +100.
        q.delete();
        fd_count = 0;
        send_frame(0, 100, NPIX);
        send_frame(100, 100, NPIX);
        repeat (3) tick();
        check("b2b_ntiles", q.size(), 8);
        check_tiles("b2b_f0", 0, 0);
        check_tiles("b2b_f1", 100, 4);
        if (q.size() >= 5) check("b2b_f1_t00_e00", q[4].tile[7:0], 100);
        check("b2b_frame_done_count", fd_count, 2);

        // Reset while pixel (4,2) is offered.
        q.delete();
        send_frame(50, 100, 4 * IW + 2);
        in_valid = 1'b1;
        in_pixel = make_pix(4, 2, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("midrst");
        q.delete();
        send_frame(0, 100, NPIX);
        repeat (3) tick();
        check("midrst_ntiles", q.size(), 4);
        check_tiles("midrst", 0, 0);

        // Sparse input: same tiles, same order.
        q.delete();
        send_frame(0, 30, NPIX);
        repeat (3) tick();
        check("sparse_ntiles", q.size(), 4);
        check_tiles("sparse", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
